// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional feature macro used by this block: MEM_ARB_ROUND_ROBIN_EN
// (round-robin contention resolution instead of fixed port-0 priority).
package memory_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  // Port indices; a grant is carried as a single bit.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DEV = 1'b1;

  // Access sequencer: sample/latch, memory negedge access, ack.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/memory_arbiter_select.sv
// Combinational winner selection for the memory arbiter.
// Macro: MEM_ARB_ROUND_ROBIN_EN -- defined: contention goes to the port
// that did not win last; undefined: port 0 always wins contention.
// Ports:
//   req0_i, req1_i   request bits of port 0 / port 1
//   last_grant_i     previous winner (round-robin build only)
//   grant_c_o        winning port index (valid when any request is high)
module memory_arbiter_select
  import memory_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_grant_i,
`endif
  output logic grant_c_o
);

  // A lone requester always wins; only contention consults the policy.
  always_comb begin
    grant_c_o = PORT_CPU;
    if (req0_i && req1_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_c_o = ~last_grant_i;
`else
      grant_c_o = PORT_CPU;
`endif
    end else if (req1_i) begin
      grant_c_o = PORT_DEV;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port arbiter sharing one negedge-sampled memory_block between a CPU
// port (0) and a device/DMA port (1). One access every three cycles:
// IDLE latches the winner onto the memory lines, the memory acts on the
// negedge inside ISSUE, DONE presents a one-cycle ack with read data.
// Macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin contention handling.
// Ports:
//   clock, reset            system clock, async active-high reset
//   pN_req/we/addr/wdata    port N request, held until pN_ack
//   pN_ack, pN_rdata        one-cycle completion, read data (held)
//   mem_write_enable, mem_read_address, mem_write_address, mem_data_in
//                           registered drive to the memory
//   mem_data_out            read data from the memory
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]    p0_wdata,
  output logic                     p0_ack,
  output logic [DATA_WIDTH-1:0]    p0_rdata,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]    p1_wdata,
  output logic                     p1_ack,
  output logic [DATA_WIDTH-1:0]    p1_rdata,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out
);

  state_e                   state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [1:0]               ack_q, ack_d;
  logic [DATA_WIDTH-1:0]    rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]    rdata1_q, rdata1_d;
  logic                     sel_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
`endif

  memory_arbiter_select u_select (
    .req0_i       (p0_req),
    .req1_i       (p1_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant_i (last_grant_q),
`endif
    .grant_c_o    (sel_c)
  );

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= PORT_CPU;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= PORT_DEV;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = 2'b00;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          grant_d     = sel_c;
          mem_we_d    = (sel_c == PORT_DEV) ? p1_we    : p0_we;
          mem_addr_d  = (sel_c == PORT_DEV) ? p1_addr  : p0_addr;
          mem_wdata_d = (sel_c == PORT_DEV) ? p1_wdata : p0_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = sel_c;
`endif
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // mem_we_q still holds the winner's direction during this cycle.
        mem_we_d = 1'b0;
        ack_d    = (grant_q == PORT_DEV) ? 2'b10 : 2'b01;
        if (!mem_we_q) begin
          if (grant_q == PORT_DEV) rdata1_d = mem_data_out;
          else                     rdata0_d = mem_data_out;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign p0_ack            = ack_q[0];
  assign p1_ack            = ack_q[1];
  assign p0_rdata          = rdata0_q;
  assign p1_rdata          = rdata1_q;
  assign mem_write_enable  = mem_we_q;
  assign mem_read_address  = mem_addr_q;
  assign mem_write_address = mem_addr_q;
  assign mem_data_in       = mem_wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: negedge memory behaviour, randomized and
// directed requesters, and a cycle-level transaction reference model.
module tb_memory_arbiter;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_init;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_write_enable;
  logic [15:0] mem_read_address, mem_write_address, mem_data_in;
  logic [15:0] mem_data_out;

  // Requester-side drive
  logic        rq_req [2];
  logic        rq_we  [2];
  logic [15:0] rq_addr [2];
  logic [15:0] rq_wdata [2];

  assign p0_req = rq_req[0];  assign p0_we = rq_we[0];
  assign p0_addr = rq_addr[0]; assign p0_wdata = rq_wdata[0];
  assign p1_req = rq_req[1];  assign p1_we = rq_we[1];
  assign p1_addr = rq_addr[1]; assign p1_wdata = rq_wdata[1];

  memory_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .p0_req            (p0_req),
    .p0_we             (p0_we),
    .p0_addr           (p0_addr),
    .p0_wdata          (p0_wdata),
    .p0_ack            (p0_ack),
    .p0_rdata          (p0_rdata),
    .p1_req            (p1_req),
    .p1_we             (p1_we),
    .p1_addr           (p1_addr),
    .p1_wdata          (p1_wdata),
    .p1_ack            (p1_ack),
    .p1_rdata          (p1_rdata),
    .mem_write_enable  (mem_write_enable),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_data_in       (mem_data_in),
    .mem_data_out      (mem_data_out)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] init_word(int i);
    return 16'(i * 16'h0101) ^ 16'hA5A5;
  endfunction

  // Memory block stand-in: acts on the negedge, 16 words.
  logic [15:0] mem [16];
  always @(negedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (mem_write_enable) begin
      mem[mem_write_address[3:0]] <= mem_data_in;
    end
    mem_data_out <= mem[mem_read_address[3:0]];
  end

  // Reference model state
  logic [15:0] ref_mem [16];
  logic [15:0] exp_rd [2];
  logic [15:0] pend;
  logic        win, win_we, last, exp_mwe, gaps;
  int          k, nxt, ack_at;
  int          n_vec, n_err;
  acc_t        q0 [$];
  acc_t        q1 [$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic pull(int p);
    acc_t a;
    rq_req[p] = 1'b0;
    if (gaps && $urandom_range(2) == 0) return;
    if (p == 0) begin
      if (q0.size() == 0) return;
      a = q0.pop_front();
    end else begin
      if (q1.size() == 0) return;
      a = q1.pop_front();
    end
    rq_req[p] = 1'b1;
    rq_we[p] = a.we;
    rq_addr[p] = a.addr;
    rq_wdata[p] = a.wdata;
  endtask

  // One clock: grant decision at this edge, output checks, requester update.
  task automatic step();
    logic ack_e [2];
    logic w;
    @(posedge clock); #1;
    k++;
    exp_mwe = 1'b0;
    if (k >= nxt && (rq_req[0] || rq_req[1])) begin
      if (rq_req[0] && rq_req[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w = ~last;
`else
        w = 1'b0;
`endif
      end else begin
        w = rq_req[1];
      end
      last = w; win = w; win_we = rq_we[w];
      if (rq_we[w]) ref_mem[rq_addr[w][3:0]] = rq_wdata[w];
      else          pend = ref_mem[rq_addr[w][3:0]];
      ack_at = k + 1;
      nxt = k + 3;
      exp_mwe = rq_we[w];
      check("mem_read_address", 32'(mem_read_address), 32'(rq_addr[w]));
      check("mem_write_address", 32'(mem_write_address), 32'(rq_addr[w]));
      if (rq_we[w]) check("mem_data_in", 32'(mem_data_in), 32'(rq_wdata[w]));
    end
    for (int p = 0; p < 2; p++) ack_e[p] = (k == ack_at) && (32'(win) == p);
    if (k == ack_at && !win_we) exp_rd[win] = pend;
    check("mem_write_enable", 32'(mem_write_enable), 32'(exp_mwe));
    check("p0_ack", 32'(p0_ack), 32'(ack_e[0]));
    check("p1_ack", 32'(p1_ack), 32'(ack_e[1]));
    check("p0_rdata", 32'(p0_rdata), 32'(exp_rd[0]));
    check("p1_rdata", 32'(p1_rdata), 32'(exp_rd[1]));
    for (int p = 0; p < 2; p++) if (ack_e[p] || !rq_req[p]) pull(p);
  endtask

  function automatic logic is_idle();
    return q0.size() == 0 && q1.size() == 0 && !rq_req[0] && !rq_req[1] && k >= nxt;
  endfunction

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      if (is_idle()) break;
      step();
    end
    check("drain_timeout", 32'(is_idle()), 32'd1);
  endtask

  task automatic model_reset();
    nxt = 0; ack_at = -10; last = 1'b1; win = 1'b0; win_we = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0; pend = '0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; k = 0; gaps = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin
      rq_req[p] = 1'b0; rq_we[p] = 1'b0; rq_addr[p] = '0; rq_wdata[p] = '0;
    end
    reset = 1'b1; mem_init = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_mem_write_enable", 32'(mem_write_enable), 32'd0);
    check("rst_mem_read_address", 32'(mem_read_address), 32'd0);
    check("rst_mem_write_address", 32'(mem_write_address), 32'd0);
    check("rst_mem_data_in", 32'(mem_data_in), 32'd0);
    check("rst_p0_ack", 32'(p0_ack), 32'd0);
    check("rst_p1_ack", 32'(p1_ack), 32'd0);
    check("rst_p0_rdata", 32'(p0_rdata), 32'd0);
    check("rst_p1_rdata", 32'(p1_rdata), 32'd0);
    @(negedge clock); #1;
    mem_init = 1'b0; reset = 1'b0;

    // Port 0 write/read-back and read of an untouched neighbour.
    q0.push_back('{1'b1, 16'h0005, 16'h1234});
    q0.push_back('{1'b0, 16'h0005, 16'h0000});
    q0.push_back('{1'b0, 16'h0004, 16'h0000});
    drain();

    // Four contended reads.
    q0.push_back('{1'b0, 16'h0005, 16'h0}); q0.push_back('{1'b0, 16'h0006, 16'h0});
    q1.push_back('{1'b0, 16'h0004, 16'h0}); q1.push_back('{1'b0, 16'h0007, 16'h0});
    drain();

    // Port 0 write seen by port 1; port 1 write leaves its rdata alone.
    q0.push_back('{1'b1, 16'h0009, 16'hCAFE});
    drain();
    q1.push_back('{1'b0, 16'h0009, 16'h0});
    q1.push_back('{1'b1, 16'h000A, 16'h5A5A});
    drain();

    // Port 0 back-to-back reads with req held high.
    q0.push_back('{1'b0, 16'h0005, 16'h0});
    q0.push_back('{1'b0, 16'h0009, 16'h0});
    q0.push_back('{1'b0, 16'h0004, 16'h0});
    drain();

    // Randomized traffic with idle gaps.
    gaps = 1'b1;
    for (int i = 0; i < 150; i++) begin
      q0.push_back('{1'($urandom_range(1)), 16'($urandom_range(15)), 16'($urandom)});
      q1.push_back('{1'($urandom_range(1)), 16'($urandom_range(15)), 16'($urandom)});
    end
    drain();
    gaps = 1'b0;

    // Reset in ISSUE before the negedge: write dropped, no ack.
    rq_req[0] = 1'b1; rq_we[0] = 1'b1; rq_addr[0] = 16'h0003; rq_wdata[0] = 16'hBEEF;
    @(posedge clock); #1;
    k++;
    check("rst_issue_we_pre", 32'(mem_write_enable), 32'd1);
    #1;
    reset = 1'b1; rq_req[0] = 1'b0;
    #1;
    check("rst_issue_we", 32'(mem_write_enable), 32'd0);
    check("rst_issue_p0_ack", 32'(p0_ack), 32'd0);
    check("rst_issue_p1_ack", 32'(p1_ack), 32'd0);
    check("rst_issue_p0_rdata", 32'(p0_rdata), 32'd0);
    check("rst_issue_p1_rdata", 32'(p1_rdata), 32'd0);
    @(negedge clock); #2;
    reset = 1'b0;
    check("rst_issue_mem_word", 32'(mem[3]), 32'(ref_mem[3]));
    model_reset();

    // After reset: immediate service and port 0 favoured on contention.
    q0.push_back('{1'b0, 16'h0003, 16'h0});
    drain();
    q0.push_back('{1'b0, 16'h0001, 16'h0});
    q1.push_back('{1'b0, 16'h0002, 16'h0});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
